pu_tag_result_collector: RTL
============================

Name: pu_tag_result_collector

Overview:
- Sits directly downstream of the PU tag lookup stage.
- Gathers the per-hit RCI results of one tag lookup (up to 8 hits) into a staging buffer, and commits them as one record when the lookup's status pulse arrives.
- Streams each committed record to the requesting PU as a beat sequence with a valid/ready handshake.
- Throttles the upstream key issue when record space runs out.

Parameters:
- RCI_NBITS, `RCI_NBITS: width of one lookup result.
- PID_NBITS, `PU_ID_NBITS: width of the PU id.
- MAX_HITS, 8: maximum results per lookup; sets staging depth.
- REC_DEPTH_NBITS, 2: log2 of the record FIFO depth (4 records).
- IN_FLIGHT, 2: lookups that may already be issued upstream and not yet committed.

Ports:
- clk  in  1  clock.
- `RESET_SIG  in  1  asynchronous, active-high reset.
- tag_lookup_valid  in  1  one hit result this cycle.
- tag_lookup_result  in  RCI_NBITS  hit payload.
- tag_lookup_result_pid  in  PID_NBITS  PU owning the hit.
- tag_lookup_result_num  in  3  hit index within the lookup.
- tag_lookup_status_valid  in  1  end-of-lookup pulse.
- tag_lookup_status  in  4  total hits for the lookup, 0..8.
- tag_lookup_status_pid  in  PID_NBITS  PU owning the lookup.
- tag_key_ready  out  1  upstream may issue a new tag key.
- res_valid  out  1  result beat valid.
- res_ready  in  1  PU accepts the beat.
- res_pid  out  PID_NBITS  destination PU.
- res_data  out  RCI_NBITS  RCI value; 0 on a miss beat.
- res_last  out  1  last beat of the record.
- res_miss  out  1  record had zero hits; single beat.
- overflow_err  out  1  sticky: a record was dropped.
- drop_cnt  out  8  saturating count of dropped records.

Behaviour:
- Reset values: all outputs 0 except tag_key_ready=1. Staging count=0, record FIFO empty, beat index=0.
- Staging:
  - On tag_lookup_valid, write tag_lookup_result at slot stage_cnt, then stage_cnt+1.
  - stage_cnt is 4 bits and saturates at MAX_HITS; extra hits are ignored and set overflow_err.
  - tag_lookup_result_num is informational. In a debug build, an assertion fires when it differs from stage_cnt.
- Commit:
  - On tag_lookup_status_valid, push {status_pid, stage_cnt, slots} into the record FIFO (sfifo2f_fo) and clear stage_cnt to 0.
  - When valid and status_valid arrive in the same cycle, the hit is included in the commit; the committed count is stage_cnt+1.
  - tag_lookup_status is not used for the count. A mismatch between it and the committed count is a diagnostic only.
  - FIFO full at commit: record dropped, overflow_err set, drop_cnt+1 (saturates at 255). Staging is still cleared.
- Backpressure: tag_key_ready is registered, =1 when free FIFO entries > IN_FLIGHT. It updates the cycle after any push or pop.
- Output FSM, states IDLE / SEND:
  - IDLE: when the FIFO is non-empty, load the head record into the output register, go to SEND, and assert res_valid the next cycle. A status pulse sampled at edge N gives res_valid high after edge N+1 (minimum latency 2).
  - SEND: a beat completes on res_valid & res_ready. res_data = slot[beat_idx]. res_last is 1 when beat_idx == count-1.
  - Last beat accepted: pop the FIFO. If another record is pending, load it back-to-back with no bubble; otherwise go to IDLE and drop res_valid.
  - count=0: one beat with res_miss=1, res_last=1, res_data=0.
  - All res_* outputs are held stable while res_valid & ~res_ready.
- Reset mid-operation: staging, FIFO and FSM are all cleared; partial records are discarded with no error flagged.

Optional Feature:
- Macro: PU_TAG_RESULT_DEDUP_EN.
- Defined: an incoming hit whose RCI equals any already-staged slot of the current lookup is discarded and stage_cnt is unchanged. The compare is combinational against all valid slots. In the same-cycle valid+status case the compare still applies.
- Undefined: every hit is stored and no comparators are built.

Decomposition:
- Shared package pu_tag_pkg: typedef tag_rec_t {pid, count[3:0], rci[MAX_HITS]}; constants MAX_HITS and the miss encoding; FSM state enum.
- Record FIFO: reuse existing sfifo2f_fo.
- Natural sub-module: pu_tag_result_stage (staging slots, counter, dedup logic).

Test Plan:
- Hits 0x11, 0x22, 0x33 then status=3 for pid 5 -> three beats, pid 5, data 11/22/33, res_last on the third; res_valid first high 2 cycles after status.
- Status=0 for pid 2 with no hits -> one beat: res_miss=1, res_last=1, res_data=0.
- 8th hit and status in the same cycle -> 8 beats, the last carrying the 8th RCI; overflow_err stays 0.
- res_ready low: 5 records committed back-to-back -> tag_key_ready falls after 2 records (free ≤ 2); 5th record dropped, drop_cnt=1, overflow_err=1; the first 4 records drain intact.
- DEDUP_EN defined: hits 0x7, 0x7, 0x9 -> 2 beats (7, 9). Undefined: 3 beats (7, 7, 9).
- Reset asserted mid-SEND -> res_valid=0 immediately, tag_key_ready=1, no stale beats after reset release.

Source files
------------

// File: rtl/pu_tag_pkg.sv
// rtl/pu_tag_pkg.sv - shared types and constants for the PU tag result collector
package pu_tag_pkg;

    localparam int TAG_RCI_NBITS = 16;
    localparam int TAG_PID_NBITS = 4;

    localparam int MAX_HITS = 8;
    // A record with zero hits is streamed as a single miss beat.
    localparam logic [3:0] MISS_COUNT = 4'd0;

    typedef struct packed {
        logic [TAG_PID_NBITS-1:0]                   pid;
        logic [3:0]                                 count;
        logic [MAX_HITS-1:0][TAG_RCI_NBITS-1:0]     rci;
    } tag_rec_t;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SEND
    } out_state_e;

endpackage

// File: rtl/pu_tag_result_stage.sv
// rtl/pu_tag_result_stage.sv - staging slots and hit counter for one lookup; PU_TAG_RESULT_DEDUP_EN drops repeated RCIs
module pu_tag_result_stage
    import pu_tag_pkg::*;
#(
    parameter int RCI_NBITS = TAG_RCI_NBITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                hit_valid,
    input  logic [RCI_NBITS-1:0]                hit_rci,
    input  logic [2:0]                          hit_num,
    input  logic                                commit,
    output logic [3:0]                          commit_cnt,
    output logic [MAX_HITS-1:0][RCI_NBITS-1:0]  commit_rci,
    output logic                                hit_dropped
);
    logic [3:0]                         stage_cnt;
    logic [MAX_HITS-1:0][RCI_NBITS-1:0] slots;
    logic                               dup_hit;
    logic                               room;
    logic                               accept;

`ifdef PU_TAG_RESULT_DEDUP_EN
    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < MAX_HITS; i++) begin
            if ((4'(i) < stage_cnt) && (slots[i] == hit_rci)) begin
                dup_hit = 1'b1;
            end
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    assign room        = (stage_cnt < 4'(MAX_HITS));
    assign accept      = hit_valid && room && !dup_hit;
    assign hit_dropped = hit_valid && !room && !dup_hit;

    // A hit arriving with the status pulse is folded into the committed record.
    always_comb begin
        commit_rci = slots;
        commit_cnt = stage_cnt;
        if (accept) begin
            commit_rci[stage_cnt[2:0]] = hit_rci;
            commit_cnt                 = stage_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_cnt <= '0;
            slots     <= '0;
        end else begin
            if (accept) begin
                slots[stage_cnt[2:0]] <= hit_rci;
            end
            if (commit) begin
                stage_cnt <= '0;
            end else if (accept) begin
                stage_cnt <= stage_cnt + 4'd1;
            end
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (rst) accept |-> (hit_num == stage_cnt[2:0]));
`endif

endmodule

// File: rtl/sfifo2f_fo.sv
// rtl/sfifo2f_fo.sv - synchronous first-word-fall-through FIFO with head and next-entry peek
module sfifo2f_fo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_NBITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [WIDTH-1:0]       dout_next,
    output logic [DEPTH_NBITS:0]   count,
    output logic                   full,
    output logic                   empty
);
    localparam int DEPTH = 1 << DEPTH_NBITS;

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH_NBITS-1:0] rd_ptr;
    logic [DEPTH_NBITS-1:0] rd_ptr_inc;
    logic [DEPTH_NBITS-1:0] wr_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full       = (count == (DEPTH_NBITS+1)'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign dout       = mem[rd_ptr];
    assign dout_next  = mem[rd_ptr_inc];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pu_tag_result_collector.sv
// rtl/pu_tag_result_collector.sv - commits staged tag hits as records and streams them per PU; PU_TAG_RESULT_DEDUP_EN enables hit dedup
module pu_tag_result_collector
    import pu_tag_pkg::*;
#(
    parameter int RCI_NBITS       = TAG_RCI_NBITS,
    parameter int PID_NBITS       = TAG_PID_NBITS,
    parameter int REC_DEPTH_NBITS = 2,
    parameter int IN_FLIGHT       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tag_lookup_valid,
    input  logic [RCI_NBITS-1:0]   tag_lookup_result,
    input  logic [PID_NBITS-1:0]   tag_lookup_result_pid,
    input  logic [2:0]             tag_lookup_result_num,
    input  logic                   tag_lookup_status_valid,
    input  logic [3:0]             tag_lookup_status,
    input  logic [PID_NBITS-1:0]   tag_lookup_status_pid,
    output logic                   tag_key_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [PID_NBITS-1:0]   res_pid,
    output logic [RCI_NBITS-1:0]   res_data,
    output logic                   res_last,
    output logic                   res_miss,
    output logic                   overflow_err,
    output logic [7:0]             drop_cnt
);
    localparam int REC_DEPTH = 1 << REC_DEPTH_NBITS;

    logic [3:0]                         commit_cnt;
    logic [MAX_HITS-1:0][RCI_NBITS-1:0] commit_rci;
    logic                               hit_dropped;
    logic                               record_drop;

    tag_rec_t                           stage_rec;
    tag_rec_t                           fifo_head;
    tag_rec_t                           fifo_next;
    tag_rec_t                           out_rec;
    logic [REC_DEPTH_NBITS:0]           fifo_count;
    logic [REC_DEPTH_NBITS:0]           fifo_free;
    logic                               fifo_full;
    logic                               fifo_empty;
    logic                               fifo_pop;

    out_state_e                         state;
    out_state_e                         state_nxt;
    logic [2:0]                         beat_idx;
    logic [2:0]                         beat_idx_nxt;
    logic                               load_head;
    logic                               load_next;
    logic                               last_beat;

    pu_tag_result_stage #(
        .RCI_NBITS (RCI_NBITS)
    ) u_stage (
        .clk         (clk),
        .rst         (rst),
        .hit_valid   (tag_lookup_valid),
        .hit_rci     (tag_lookup_result),
        .hit_num     (tag_lookup_result_num),
        .commit      (tag_lookup_status_valid),
        .commit_cnt  (commit_cnt),
        .commit_rci  (commit_rci),
        .hit_dropped (hit_dropped)
    );

    always_comb begin
        stage_rec       = '0;
        stage_rec.pid   = tag_lookup_status_pid;
        stage_rec.count = commit_cnt;
        stage_rec.rci   = commit_rci;
    end

    sfifo2f_fo #(
        .WIDTH       ($bits(tag_rec_t)),
        .DEPTH_NBITS (REC_DEPTH_NBITS)
    ) u_rec_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_lookup_status_valid),
        .din       (stage_rec),
        .pop       (fifo_pop),
        .dout      (fifo_head),
        .dout_next (fifo_next),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign record_drop = tag_lookup_status_valid && fifo_full;
    assign fifo_free   = (REC_DEPTH_NBITS+1)'(REC_DEPTH) - fifo_count;

    // The record being streamed stays at the FIFO head until its last beat is taken.
    assign last_beat = (out_rec.count == MISS_COUNT) ||
                       ({1'b0, beat_idx} == (out_rec.count - 4'd1));

    always_comb begin
        state_nxt    = state;
        beat_idx_nxt = beat_idx;
        load_head    = 1'b0;
        load_next    = 1'b0;
        fifo_pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load_head    = 1'b1;
                    beat_idx_nxt = '0;
                    state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (res_ready) begin
                    if (last_beat) begin
                        fifo_pop     = 1'b1;
                        beat_idx_nxt = '0;
                        if (fifo_count > (REC_DEPTH_NBITS+1)'(1)) begin
                            load_next = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        beat_idx_nxt = beat_idx + 3'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat_idx <= '0;
            out_rec  <= '0;
        end else begin
            state    <= state_nxt;
            beat_idx <= beat_idx_nxt;
            if (load_head) begin
                out_rec <= fifo_head;
            end else if (load_next) begin
                out_rec <= fifo_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_key_ready <= 1'b1;
            overflow_err  <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            tag_key_ready <= (fifo_free > (REC_DEPTH_NBITS+1)'(IN_FLIGHT));
            if (record_drop || hit_dropped) begin
                overflow_err <= 1'b1;
            end
            if (record_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign res_valid = (state == ST_SEND);
    assign res_pid   = res_valid ? out_rec.pid : '0;
    assign res_miss  = res_valid && (out_rec.count == MISS_COUNT);
    assign res_last  = res_valid && last_beat;
    assign res_data  = (res_valid && !res_miss) ? out_rec.rci[beat_idx] : '0;

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (rst)
        tag_lookup_status_valid |-> (tag_lookup_status == commit_cnt));
`endif

endmodule
